// File: rtl/ro_drain_pkg.sv
// Shared types, default widths and size helpers for the RO sample drain.
// Build option: RO_SAMPLE_DRAIN_FLUSH_EN adds a flush input to ro_sample_drain.
package ro_drain_pkg;

   localparam int DEF_SAMPLE_WIDTH = 32;
   localparam int DEF_LINE_WIDTH   = 512;
   localparam int DEF_ADDR_WIDTH   = 32;
   localparam int DEF_COUNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   // Samples per line.
   function automatic int calc_spl(input int line_width, input int sample_width);
      return line_width / sample_width;
   endfunction

   function automatic int calc_line_bytes(input int line_width);
      return line_width / 8;
   endfunction

endpackage

// File: rtl/ro_sample_drain_if.sv
// FIFO read port and host write-request port of the sample drain.
// Write handshake: a line transfers on a cycle where wr_valid && wr_ready;
// wr_valid, wr_addr and wr_data hold steady until then, and wr_ready is
// ignored while wr_valid is low.
interface ro_sample_drain_if #(
   parameter int SAMPLE_WIDTH = 32,
   parameter int LINE_WIDTH   = 512,
   parameter int ADDR_WIDTH   = 32
) ();

   logic                    fifo_empty;
   logic [SAMPLE_WIDTH-1:0] fifo_rd_data;
   logic                    fifo_rd_en;
   logic                    wr_valid;
   logic                    wr_ready;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [LINE_WIDTH-1:0]   wr_data;

   modport master (
      input  fifo_empty, fifo_rd_data, wr_ready,
      output fifo_rd_en, wr_valid, wr_addr, wr_data
   );

   modport slave (
      output fifo_empty, fifo_rd_data, wr_ready,
      input  fifo_rd_en, wr_valid, wr_addr, wr_data
   );

endinterface

// File: rtl/ro_line_packer.sv
// Packs successive samples into one line register, first sample in the LSBs.
// A flush zero-fills the unused upper slots and closes the line early.
module ro_line_packer
   import ro_drain_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
   parameter int LINE_WIDTH   = DEF_LINE_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_clear,
   input  logic                    i_load,
   input  logic                    i_flush,
   input  logic [SAMPLE_WIDTH-1:0] i_data,
   output logic [LINE_WIDTH-1:0]   o_line,
   output logic                    o_full,
   output logic                    o_partial
);

   localparam int SPL   = calc_spl(LINE_WIDTH, SAMPLE_WIDTH);
   localparam int IDX_W = (SPL > 1) ? $clog2(SPL) : 1;

   logic [IDX_W-1:0]      r_idx;
   logic [LINE_WIDTH-1:0] r_line;
   logic                  w_last;

   assign w_last    = (r_idx == IDX_W'(SPL - 1));
   // Asserted in the cycle whose load or flush closes the line.
   assign o_full    = (i_load && w_last) || i_flush;
   assign o_partial = (r_idx != '0);
   assign o_line    = r_line;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx  <= '0;
         r_line <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
      end else if (i_flush) begin
         for (int i = 0; i < SPL; i++) begin
            if (IDX_W'(i) >= r_idx) r_line[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= '0;
         end
         r_idx <= '0;
      end else if (i_load) begin
         r_line[r_idx*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= i_data;
         r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/ro_sample_drain.sv
// Drains RO power-sensor samples into 512-bit lines and writes them to the host.
// Build option: RO_SAMPLE_DRAIN_FLUSH_EN adds input flush to send a partial line.
module ro_sample_drain
   import ro_drain_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
   parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [COUNT_WIDTH-1:0] num_lines,
`ifdef RO_SAMPLE_DRAIN_FLUSH_EN
   input  logic                   flush,
`endif
   ro_sample_drain_if.master      bus,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] lines_written,
   output state_t                 dbg_state
);

   localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(calc_line_bytes(LINE_WIDTH));

   state_t                 r_state;
   state_t                 w_next;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [COUNT_WIDTH-1:0] r_num;
   logic [COUNT_WIDTH-1:0] r_lines;
   logic                   w_pop;
   logic                   w_clear;
   logic                   w_flush_req;
   logic                   w_flush_take;
   logic                   w_full;
   logic                   w_partial;
   logic [LINE_WIDTH-1:0]  w_line;

`ifdef RO_SAMPLE_DRAIN_FLUSH_EN
   assign w_flush_req = flush;
`else
   assign w_flush_req = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_pop        = 1'b0;
      w_clear      = 1'b0;
      w_flush_take = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_clear = 1'b1;
               w_next  = (num_lines == '0) ? DONE : FILL;
            end
         end
         FILL: begin
            // A flush of a partial line takes priority over popping.
            w_flush_take = w_flush_req && w_partial;
            w_pop        = !bus.fifo_empty && !w_flush_take;
            if (w_full) w_next = SEND;
         end
         SEND: begin
            if (bus.wr_ready)
               w_next = ((r_lines + COUNT_WIDTH'(1)) == r_num) ? DONE : FILL;
         end
         DONE: begin
            if (!start) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_num   <= '0;
         r_lines <= '0;
      end else if (r_state == IDLE && start) begin
         r_addr  <= base_addr;
         r_num   <= num_lines;
         r_lines <= '0;
      end else if (r_state == SEND && bus.wr_ready) begin
         r_lines <= r_lines + COUNT_WIDTH'(1);
         r_addr  <= r_addr + LINE_BYTES;
      end
   end

   ro_line_packer #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .LINE_WIDTH   (LINE_WIDTH)
   ) u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_clear),
      .i_load    (w_pop),
      .i_flush   (w_flush_take),
      .i_data    (bus.fifo_rd_data),
      .o_line    (w_line),
      .o_full    (w_full),
      .o_partial (w_partial)
   );

   assign bus.fifo_rd_en = w_pop;
   assign bus.wr_valid   = (r_state == SEND);
   assign bus.wr_addr    = r_addr;
   assign bus.wr_data    = w_line;
   assign busy           = (r_state == FILL) || (r_state == SEND);
   assign done           = (r_state == DONE);
   assign lines_written  = r_lines;
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_ro_sample_drain.sv
// Directed bench for ro_sample_drain: FIFO model, write-port monitor, linear test steps.
module tb_ro_sample_drain;
  import ro_drain_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_lines = '0;
`ifdef RO_SAMPLE_DRAIN_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        busy, done;
  logic [15:0] lines_written;
  state_t      dbg_state;

  ro_sample_drain_if bus ();

  ro_sample_drain dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .num_lines     (num_lines),
`ifdef RO_SAMPLE_DRAIN_FLUSH_EN
    .flush         (flush),
`endif
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .lines_written (lines_written),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  // FIFO model, monitor and scoreboard state
  logic [31:0]  fifo_q[$];
  logic [31:0]  acc_addr_q[$];
  logic [511:0] acc_data_q[$];
  int           acc_cyc_q[$];
  int           pop_cyc_q[$];
  int           cyc = 0;
  int           pop_count = 0;
  int           underflow = 0;
  int           overlap = 0;
  int           n_vec = 0;
  int           n_err = 0;

  always @(posedge clk) begin
    cyc++;
    if (bus.fifo_rd_en) begin
      if (fifo_q.size() == 0) underflow++;
      else begin
        fifo_q.delete(0);
        pop_count++;
        pop_cyc_q.push_back(cyc);
      end
    end
    if (bus.wr_valid && bus.wr_ready) begin
      acc_addr_q.push_back(bus.wr_addr);
      acc_data_q.push_back(bus.wr_data);
      acc_cyc_q.push_back(cyc);
    end
    if (bus.fifo_rd_en && bus.wr_valid) overlap++;
  end

  always @(negedge clk) begin
    bus.fifo_empty   = (fifo_q.size() == 0);
    bus.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input int first, input int n);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < n; i++) l[i*32 +: 32] = 32'(first + i);
    return l;
  endfunction

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(32'(first + i));
  endtask

  task automatic clear_logs();
    acc_addr_q.delete();
    acc_data_q.delete();
    acc_cyc_q.delete();
    pop_cyc_q.delete();
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [15:0] n, output int c_start);
    @(negedge clk);
    base_addr = base;
    num_lines = n;
    start     = 1'b1;
    c_start   = cyc;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 512'(done), 512'(1'b1));
  endtask

  task automatic end_xfer(input string tag);
    @(negedge clk);
    start = 1'b0;
    base_addr = 32'hDEAD_0000;
    num_lines = 16'd7;
    @(negedge clk);
    chk(tag, 512'(done), 512'(1'b0));
  endtask

  task automatic wait_pops(input int target, input int limit);
    int n;
    n = 0;
    while (pop_count < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("pop_wait", 512'(pop_count), 512'(target));
  endtask

  initial begin
    int c0, p0;
    logic [31:0]  hold_addr;
    logic [511:0] hold_data;
    bus.wr_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 512'(dbg_state), 512'(IDLE));
    chk("rst_outs", {bus.wr_valid, bus.fifo_rd_en, busy, done}, 512'(0));
    chk("rst_lines", 512'(lines_written), 512'(0));
    chk("rst_addr", 512'(bus.wr_addr), 512'(0));
    chk("rst_data", bus.wr_data, 512'(0));
    rst_n = 1'b1;

    // Test 1: single line
    clear_logs();
    push_words(0, 16);
    @(negedge clk);
    p0 = pop_count;
    start_xfer(32'h1000, 16'd1, c0);
    wait_done("t1_done", 100);
    chk("t1_first_pop", 512'(pop_cyc_q[0]), 512'(c0 + 2));
    chk("t1_valid_lat", 512'(acc_cyc_q[0] - pop_cyc_q[0]), 512'(16));
    chk("t1_nacc", 512'(acc_addr_q.size()), 512'(1));
    chk("t1_addr", 512'(acc_addr_q[0]), 512'(32'h1000));
    chk("t1_data", acc_data_q[0], mk_line(0, 16));
    chk("t1_lines", 512'(lines_written), 512'(1));
    chk("t1_pops", 512'(pop_count - p0), 512'(16));
    end_xfer("t1_done_clr");

    // Test 2: three back-to-back lines
    clear_logs();
    push_words(100, 48);
    p0 = pop_count;
    start_xfer(32'h1000, 16'd3, c0);
    wait_done("t2_done", 200);
    chk("t2_nacc", 512'(acc_addr_q.size()), 512'(3));
    chk("t2_addr0", 512'(acc_addr_q[0]), 512'(32'h1000));
    chk("t2_addr1", 512'(acc_addr_q[1]), 512'(32'h1040));
    chk("t2_addr2", 512'(acc_addr_q[2]), 512'(32'h1080));
    chk("t2_data2", acc_data_q[2], mk_line(132, 16));
    chk("t2_thru", 512'(acc_cyc_q[1] - acc_cyc_q[0]), 512'(17));
    chk("t2_pops", 512'(pop_count - p0), 512'(48));
    chk("t2_fifo_empty", 512'(fifo_q.size()), 512'(0));
    chk("t2_lines", 512'(lines_written), 512'(3));
    chk("t2_overlap", 512'(overlap), 512'(0));
    end_xfer("t2_done_clr");

    // Test 3: FIFO runs dry after word 7
    clear_logs();
    push_words(200, 8);
    p0 = pop_count;
    start_xfer(32'h3000, 16'd1, c0);
    wait_pops(p0 + 8, 50);
    repeat (5) @(negedge clk);
    chk("t3_stall_state", 512'(dbg_state), 512'(FILL));
    chk("t3_stall_rden", 512'(bus.fifo_rd_en), 512'(0));
    repeat (5) @(negedge clk);
    push_words(208, 8);
    wait_done("t3_done", 100);
    chk("t3_data", acc_data_q[0], mk_line(200, 16));
    chk("t3_underflow", 512'(underflow), 512'(0));
    chk("t3_pops", 512'(pop_count - p0), 512'(16));
    end_xfer("t3_done_clr");

    // Test 4: back-pressure in SEND
    clear_logs();
    bus.wr_ready = 1'b0;
    push_words(400, 16);
    p0 = pop_count;
    start_xfer(32'h4000, 16'd1, c0);
    for (int n = 0; n < 60 && !bus.wr_valid; n++) @(negedge clk);
    chk("t4_valid", 512'(bus.wr_valid), 512'(1));
    hold_addr = bus.wr_addr;
    hold_data = bus.wr_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", 512'(bus.wr_valid), 512'(1));
      chk("t4_hold_addr", 512'(bus.wr_addr), 512'(hold_addr));
      chk("t4_hold_data", bus.wr_data, hold_data);
      chk("t4_hold_rden", 512'(bus.fifo_rd_en), 512'(0));
    end
    chk("t4_addr", 512'(hold_addr), 512'(32'h4000));
    bus.wr_ready = 1'b1;
    wait_done("t4_done", 20);
    chk("t4_nacc", 512'(acc_addr_q.size()), 512'(1));
    chk("t4_data", acc_data_q[0], mk_line(400, 16));
    chk("t4_pops", 512'(pop_count - p0), 512'(16));
    end_xfer("t4_done_clr");

    // Test 5: zero lines
    clear_logs();
    push_words(600, 3);
    p0 = pop_count;
    start_xfer(32'h5000, 16'd0, c0);
    @(negedge clk);
    chk("t5_done", 512'(done), 512'(1));
    chk("t5_busy", 512'(busy), 512'(0));
    @(negedge clk);
    chk("t5_pops", 512'(pop_count - p0), 512'(0));
    chk("t5_nacc", 512'(acc_addr_q.size()), 512'(0));
    end_xfer("t5_done_clr");
    fifo_q.delete();

    // Test 6: reset mid line 2, then restart
    clear_logs();
    push_words(300, 32);
    p0 = pop_count;
    start_xfer(32'h1000, 16'd2, c0);
    wait_pops(p0 + 21, 100);
    rst_n = 1'b0;
    #1;
    chk("t6_async_busy", 512'(busy), 512'(0));
    chk("t6_async_lines", 512'(lines_written), 512'(0));
    chk("t6_async_addr", 512'(bus.wr_addr), 512'(0));
    chk("t6_async_data", bus.wr_data, 512'(0));
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_pop", 512'(pop_count - p0), 512'(21));
    chk("t6_fifo_kept", 512'(fifo_q.size()), 512'(11));
    rst_n = 1'b1;
    clear_logs();
    push_words(332, 5);
    start_xfer(32'h2000, 16'd1, c0);
    @(negedge clk);
    chk("t6_restart_lines", 512'(lines_written), 512'(0));
    chk("t6_restart_busy", 512'(busy), 512'(1));
    wait_done("t6_done", 100);
    chk("t6_addr", 512'(acc_addr_q[0]), 512'(32'h2000));
    chk("t6_data", acc_data_q[0], mk_line(321, 16));
    chk("t6_lines", 512'(lines_written), 512'(1));
    end_xfer("t6_done_clr");

`ifdef RO_SAMPLE_DRAIN_FLUSH_EN
    // Flush after four pops
    clear_logs();
    push_words(500, 6);
    p0 = pop_count;
    start_xfer(32'h6000, 16'd1, c0);
    wait_pops(p0 + 4, 50);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_done("fl_done", 20);
    chk("fl_data", acc_data_q[0], mk_line(500, 4));
    chk("fl_pops", 512'(pop_count - p0), 512'(4));
    chk("fl_fifo_left", 512'(fifo_q.size()), 512'(2));
    end_xfer("fl_done_clr");
    fifo_q.delete();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
